fifo_flagged: RTL
=================

Name: fifo_flagged

Overview:
- Next-generation synchronous FIFO for the same datapath family as the basic push/pop FIFO.
- Generalised over word width and depth. Depth need not be a power of two.
- Adds an occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags, and defined simultaneous push/pop behaviour.
- Sits between a producer and a consumer in one clock domain. Exposes a show-ahead head word plus a registered dout.

Parameters:
- WL, 8, data word width in bits (>=1).
- N, 6, depth in entries (>=2; any integer).
- A_WL, $clog2(N), address/pointer width.
- C_WL, $clog2(N+1), width of COUNT.
- AF_TH, N-1, ALMOST_FULL asserts when COUNT >= AF_TH (1..N).
- AE_TH, 1, ALMOST_EMPTY asserts when COUNT <= AE_TH (0..N-1).

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- PUSH  in  1  write request; din is written when accepted.
- POP  in  1  read request.
- din  in  WL  write data.
- CLR_ERR  in  1  synchronous clear of OVF/UDF.
- head  out  WL  oldest stored word (show-ahead); valid only when EMPTY=0.
- dout  out  WL  registered copy of the word removed by the last accepted POP.
- COUNT  out  C_WL  current occupancy, 0..N.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==N.
- ALMOST_EMPTY  out  1  COUNT<=AE_TH.
- ALMOST_FULL  out  1  COUNT>=AF_TH.
- OVF  out  1  sticky: a PUSH was rejected.
- UDF  out  1  sticky: a POP was rejected.

Behaviour:
- Interface decided: one clock CLK; reset RST_N is asynchronous, active-low.
- Reset (RST_N=0, takes effect immediately, independent of CLK):
  - wr_ptr=0, rd_ptr=0, COUNT=0, dout=0, OVF=0, UDF=0.
  - EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_TH==0 ? 1 : 0).
  - Memory contents are not reset.
  - Reset asserted mid-operation discards all stored data.
- Acceptance, evaluated on the pre-edge state:
  - push_ok = PUSH & (~FULL | POP).
  - pop_ok = POP & ~EMPTY.
- On the rising edge:
  - push_ok: mem[wr_ptr] <= din; wr_ptr advances.
  - pop_ok: dout <= mem[rd_ptr]; rd_ptr advances.
  - COUNT <= COUNT + push_ok - pop_ok.
- Pointer wrap: a pointer equal to N-1 advances to 0, otherwise it increments by 1. No power-of-two aliasing is relied on.
- Simultaneous PUSH and POP:
  - Not full, not empty: both accepted; COUNT unchanged.
  - FULL: both accepted; the freed slot takes din; COUNT stays N; no OVF.
  - EMPTY: push accepted; pop rejected and sets UDF; COUNT becomes 1. There is no write-through: dout is not updated.
- Latency:
  - head reflects a pushed word one cycle after the push edge, once EMPTY falls.
  - dout updates on the same edge that accepts the POP.
  - dout holds its value when no pop is accepted.
- Errors:
  - PUSH & FULL & ~POP sets OVF; data and pointers are unchanged.
  - POP & EMPTY sets UDF.
  - Both flags stay set until CLR_ERR=1 at an edge.
  - If CLR_ERR and a new error occur in the same cycle, the error wins (flag stays 1).
- Flags:
  - EMPTY, FULL, ALMOST_* are combinational decodes of the registered COUNT only.
  - No combinational path from PUSH/POP to any output.
- head = mem[rd_ptr], combinational read. Its value is don't-care when EMPTY=1.

Decomposition:
- Shared include/package fifo_pkg holds:
  - clog2-based width helpers.
  - Default WL/N constants.
  - Localparams for the reset value of dout.
- One sub-module, fifo_ptr: a parametrised modulo-N pointer counter with ports CLK, RST_N, INC, ptr[A_WL-1:0].
  - Instantiated twice (write and read pointer).
- Storage is an inferred reg array inside fifo_flagged.

Test Plan:
- Reset then idle: RST_N=0 for 2 cycles, release -> COUNT=0, EMPTY=1, ALMOST_EMPTY=1, FULL=0, OVF=0, UDF=0, dout=0. Asserting RST_N low between edges clears COUNT immediately.
- Fill and wrap, N=6: push 1..6 -> FULL=1, COUNT=6, ALMOST_FULL from COUNT=5. Pop 3 -> dout 1,2,3. Push 7,8,9 (wr_ptr wraps 5->0) -> pops return 4,5,6,7,8,9 in order; EMPTY=1 after the last.
- Overflow: fill to 6, PUSH din=A without POP -> OVF=1, COUNT=6, next pops still return 1..6. CLR_ERR pulse -> OVF=0.
- Underflow: on empty, POP -> UDF=1, COUNT=0, dout unchanged. PUSH+POP together on empty -> COUNT=1, UDF=1, head=din.
- Simultaneous at full: FULL with head=1, PUSH din=0x55 + POP -> dout=1, COUNT=6, OVF=0. Draining returns 2..6 then 0x55.
- Thresholds: AF_TH=4, AE_TH=2 -> ALMOST_EMPTY=1 for COUNT 0..2; ALMOST_FULL=1 for COUNT 4..6; both checked on each push/pop step.

Source files
------------

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_pkg
// Description : Shared constants and width helpers for the flagged FIFO
//               family (default word width/depth, pointer/count widths,
//               reset value of the registered read port).
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

  localparam int DEF_WL = 8;
  localparam int DEF_N  = 6;

  // Every bit of dout comes out of reset at this value.
  localparam logic DOUT_RST_BIT = 1'b0;

  // Pointer width able to address entries 0..depth-1 (at least one bit).
  function automatic int ptr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count width able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_ptr.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr
// Description : Modulo-N pointer counter. Advances by one on INC and wraps
//               from N-1 back to 0, so N need not be a power of two.
// Ports       : CLK   - clock, rising edge
//               RST_N - asynchronous active-low reset (pointer -> 0)
//               INC   - advance the pointer this edge
//               ptr   - current pointer value
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int N    = DEF_N,
  parameter int A_WL = ptr_width(N)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            INC,
  output logic [A_WL-1:0] ptr
);

  localparam logic [A_WL-1:0] C_LAST = A_WL'(N - 1);

  logic [A_WL-1:0] r_ptr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ptr <= '0;
    end else if (INC) begin
      // Explicit wrap at N-1; never rely on natural binary rollover.
      r_ptr <= (r_ptr == C_LAST) ? '0 : r_ptr + A_WL'(1);
    end
  end

  assign ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/fifo_flagged.sv
`default_nettype none
// ============================================================================
// Module      : fifo_flagged
// Description : Single-clock FIFO with occupancy count, programmable
//               almost-full/almost-empty flags, sticky overflow/underflow
//               flags, show-ahead head word and a registered dout.
// Ports       : CLK, RST_N          - clock / async active-low reset
//               PUSH, din           - write request and data
//               POP                 - read request
//               CLR_ERR             - clears OVF/UDF at the edge
//               head                - oldest stored word (valid when !EMPTY)
//               dout                - word removed by the last accepted POP
//               COUNT               - occupancy 0..N
//               EMPTY, FULL         - COUNT==0 / COUNT==N
//               ALMOST_EMPTY/FULL   - COUNT<=AE_TH / COUNT>=AF_TH
//               OVF, UDF            - sticky rejected-push / rejected-pop
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_flagged
  import fifo_pkg::*;
#(
  parameter int WL    = DEF_WL,
  parameter int N     = DEF_N,
  parameter int A_WL  = ptr_width(N),
  parameter int C_WL  = count_width(N),
  parameter int AF_TH = N - 1,
  parameter int AE_TH = 1
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            PUSH,
  input  logic            POP,
  input  logic [WL-1:0]   din,
  input  logic            CLR_ERR,
  output logic [WL-1:0]   head,
  output logic [WL-1:0]   dout,
  output logic [C_WL-1:0] COUNT,
  output logic            EMPTY,
  output logic            FULL,
  output logic            ALMOST_EMPTY,
  output logic            ALMOST_FULL,
  output logic            OVF,
  output logic            UDF
);

  localparam logic [C_WL-1:0] C_FULL  = C_WL'(N);
  localparam logic [C_WL-1:0] C_AF_TH = C_WL'(AF_TH);
  localparam logic [C_WL-1:0] C_AE_TH = C_WL'(AE_TH);

  logic [WL-1:0]   r_mem [N];
  logic [A_WL-1:0] w_wr_ptr;
  logic [A_WL-1:0] w_rd_ptr;
  logic [C_WL-1:0] r_count;
  logic [WL-1:0]   r_dout;
  logic            r_ovf;
  logic            r_udf;

  logic w_empty;
  logic w_full;
  logic w_push_ok;
  logic w_pop_ok;
  logic w_ovf_evt;
  logic w_udf_evt;

  // Status decodes depend on the registered count only.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == C_FULL);

  // A push into a full FIFO is still accepted when a pop frees a slot.
  assign w_push_ok = PUSH & (~w_full | POP);
  assign w_pop_ok  = POP & ~w_empty;
  assign w_ovf_evt = PUSH & w_full & ~POP;
  assign w_udf_evt = POP & w_empty;

  fifo_ptr #(.N(N), .A_WL(A_WL)) u_wr_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INC   (w_push_ok),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr #(.N(N), .A_WL(A_WL)) u_rd_ptr (
    .CLK   (CLK),
    .RST_N (RST_N),
    .INC   (w_pop_ok),
    .ptr   (w_rd_ptr)
  );

  // Storage is deliberately not reset.
  always_ff @(posedge CLK) begin
    if (w_push_ok) begin
      r_mem[w_wr_ptr] <= din;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count <= '0;
    end else begin
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + C_WL'(1);
        2'b01:   r_count <= r_count - C_WL'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // dout reads the slot being vacated; a rejected pop leaves it untouched,
  // so a push+pop on an empty FIFO does not write through.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_dout <= {WL{DOUT_RST_BIT}};
    end else if (w_pop_ok) begin
      r_dout <= r_mem[w_rd_ptr];
    end
  end

  // A new error in the same cycle as CLR_ERR keeps the flag set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
    end else begin
      if (w_ovf_evt)    r_ovf <= 1'b1;
      else if (CLR_ERR) r_ovf <= 1'b0;
      if (w_udf_evt)    r_udf <= 1'b1;
      else if (CLR_ERR) r_udf <= 1'b0;
    end
  end

  assign head         = r_mem[w_rd_ptr];
  assign dout         = r_dout;
  assign COUNT        = r_count;
  assign EMPTY        = w_empty;
  assign FULL         = w_full;
  assign ALMOST_EMPTY = (r_count <= C_AE_TH);
  assign ALMOST_FULL  = (r_count >= C_AF_TH);
  assign OVF          = r_ovf;
  assign UDF          = r_udf;

endmodule
`default_nettype wire
